// File: rtl/frame_minmax_tracker.sv
// frame_minmax_tracker: streaming per-frame min/max tracker with first-occurrence
// indices. Samples arrive on a valid/ready input; each completed frame's result
// is held on a valid/ready output until consumed. tc selects unsigned or
// two's-complement ordering for the whole frame (latched on its first sample).
module frame_minmax_tracker #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int IDXW      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tc,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_min_idx,
  output logic [IDXW-1:0]  out_max_idx,
  output logic             out_tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

  state_t           state;
  logic             tc_q;
  logic [WIDTH-1:0] cur_min;
  logic [WIDTH-1:0] cur_max;
  logic [IDXW-1:0]  cur_min_idx;
  logic [IDXW-1:0]  cur_max_idx;
  logic [IDXW-1:0]  count;

  logic             accept;
  logic             last;
  logic             cmp_tc;
  logic [WIDTH-1:0] nxt_min;
  logic [WIDTH-1:0] nxt_max;
  logic [IDXW-1:0]  nxt_min_idx;
  logic [IDXW-1:0]  nxt_max_idx;

  // Signed ordering is obtained by flipping the MSB of both operands and
  // comparing unsigned.
  function automatic logic less_than(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic             s);
    logic [WIDTH-1:0] flip;
    flip          = '0;
    flip[WIDTH-1] = s;
    return (a ^ flip) < (b ^ flip);
  endfunction

  // Next running min/max for the sample currently offered; ties never update.
  always_comb begin
    accept      = in_valid & in_ready;
    // count is zero in IDLE, so this also covers FRAME_LEN==1 on the first sample
    last        = (count == LAST_IDX);
    cmp_tc      = (state == IDLE) ? tc : tc_q;
    nxt_min     = cur_min;
    nxt_max     = cur_max;
    nxt_min_idx = cur_min_idx;
    nxt_max_idx = cur_max_idx;
    if (state == IDLE) begin
      nxt_min     = in_data;
      nxt_max     = in_data;
      nxt_min_idx = '0;
      nxt_max_idx = '0;
    end else begin
      if (less_than(in_data, cur_min, cmp_tc)) begin
        nxt_min     = in_data;
        nxt_min_idx = count;
      end
      if (less_than(cur_max, in_data, cmp_tc)) begin
        nxt_max     = in_data;
        nxt_max_idx = count;
      end
    end
  end

  // Frame FSM with registered handshake flags and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      tc_q        <= 1'b0;
      cur_min     <= '0;
      cur_max     <= '0;
      cur_min_idx <= '0;
      cur_max_idx <= '0;
      count       <= '0;
      out_min     <= '0;
      out_max     <= '0;
      out_min_idx <= '0;
      out_max_idx <= '0;
      out_tc      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            cur_min     <= nxt_min;
            cur_max     <= nxt_max;
            cur_min_idx <= nxt_min_idx;
            cur_max_idx <= nxt_max_idx;
            tc_q        <= cmp_tc;
            if (last) begin
              // counter is cleared here rather than wrapped so any FRAME_LEN works
              count       <= '0;
              state       <= HOLD;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              busy        <= 1'b0;
              out_min     <= nxt_min;
              out_max     <= nxt_max;
              out_min_idx <= nxt_min_idx;
              out_max_idx <= nxt_max_idx;
              out_tc      <= cmp_tc;
            end else begin
              count <= count + 1'b1;
              state <= ACCUM;
              busy  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          count     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Testbench for frame_minmax_tracker: an 8-sample instance for directed and
// random frames, and a 2-sample instance for exhaustive pair ordering.
module tb_frame_minmax_tracker;

  typedef struct {
    logic [3:0] mn;
    logic [3:0] mx;
    int         mni;
    int         mxi;
    logic       t;
  } res_t;

  logic       clock, reset;
  logic       tc, in_valid, in_ready, out_valid, out_ready, out_tc, busy;
  logic [3:0] in_data, out_min, out_max;
  logic [2:0] out_min_idx, out_max_idx;

  logic       tc2, in_valid2, in_ready2, out_valid2, out_ready2, out_tc2, busy2;
  logic [3:0] in_data2, out_min2, out_max2;
  logic [0:0] out_min_idx2, out_max_idx2;

  res_t q8[$];
  res_t q2[$];
  int   checks = 0;
  int   errors = 0;
  bit   rr_rand = 0;
  bit   force8  = 1;

  frame_minmax_tracker #(.WIDTH(4), .FRAME_LEN(8)) dut8 (
    .clock(clock), .reset(reset), .tc(tc), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_min_idx(out_min_idx),
    .out_max_idx(out_max_idx), .out_tc(out_tc), .busy(busy));

  frame_minmax_tracker #(.WIDTH(4), .FRAME_LEN(2)) dut2 (
    .clock(clock), .reset(reset), .tc(tc2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_min(out_min2), .out_max(out_max2), .out_min_idx(out_min_idx2),
    .out_max_idx(out_max_idx2), .out_tc(out_tc2), .busy(busy2));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ordering key: plain value, or its two's-complement interpretation.
  function automatic int key(input logic [3:0] v, input bit t);
    return t ? int'($signed(v)) : int'(v);
  endfunction

  function automatic res_t model(input logic [3:0] s[$], input bit t);
    res_t r;
    r.mn = s[0]; r.mx = s[0]; r.mni = 0; r.mxi = 0; r.t = t;
    for (int i = 1; i < s.size(); i++) begin
      if (key(s[i], t) < key(r.mn, t)) begin r.mn = s[i]; r.mni = i; end
      if (key(s[i], t) > key(r.mx, t)) begin r.mx = s[i]; r.mxi = i; end
    end
    return r;
  endfunction

  function automatic res_t model8(input logic [3:0] s[8], input bit t);
    logic [3:0] q[$];
    for (int i = 0; i < 8; i++) q.push_back(s[i]);
    return model(q, t);
  endfunction

  function automatic res_t mk(input logic [3:0] mn, input int mni,
                              input logic [3:0] mx, input int mxi, input bit t);
    res_t r;
    r.mn = mn; r.mni = mni; r.mx = mx; r.mxi = mxi; r.t = t;
    return r;
  endfunction

  // Output-ready generation, changed just after each rising edge.
  initial begin
    out_ready  = 1;
    out_ready2 = 1;
    forever begin
      @(posedge clock);
      #2;
      out_ready  = rr_rand ? 1'($urandom % 2) : force8;
      out_ready2 = ($urandom % 4) != 0;
    end
  end

  // Monitor for the 8-sample instance: compare on every consumed result.
  initial begin
    res_t e;
    forever begin
      @(negedge clock);
      #1;
      if (out_valid && out_ready) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected8 actual=result required=none at %0t", $time);
        end else begin
          e = q8.pop_front();
          chk("min8", out_min, e.mn);
          chk("max8", out_max, e.mx);
          chk("min_idx8", out_min_idx, e.mni);
          chk("max_idx8", out_max_idx, e.mxi);
          chk("tc8", out_tc, e.t);
        end
      end
    end
  end

  // Monitor for the 2-sample instance.
  initial begin
    res_t e;
    forever begin
      @(negedge clock);
      #1;
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected2 actual=result required=none at %0t", $time);
        end else begin
          e = q2.pop_front();
          chk("min2", out_min2, e.mn);
          chk("max2", out_max2, e.mx);
          chk("min_idx2", out_min_idx2, e.mni);
          chk("max_idx2", out_max_idx2, e.mxi);
          chk("tc2", out_tc2, e.t);
        end
      end
    end
  end

  // Drives nsend samples; tc switches from t0 to t1 from the third sample on.
  // Returns at the falling edge after the last accept with in_valid low.
  task automatic send8(input logic [3:0] s[8], input bit t0, input bit t1,
                       input int gap_pct, input int nsend);
    for (int i = 0; i < nsend; i++) begin
      int w;
      for (int g = 0; g < 3; g++) begin
        if (int'($urandom_range(99)) < gap_pct) begin
          @(negedge clock);
          in_valid = 0;
          in_data  = 4'($urandom);
        end
      end
      @(negedge clock);
      in_valid = 1;
      in_data  = s[i];
      tc       = (i < 2) ? t0 : t1;
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge clock);
        w++;
      end
      if (w == 200) begin
        checks++; errors++;
        $display("FAIL in_ready8 timeout actual=0 required=1 at %0t", $time);
      end
      @(posedge clock);
    end
    @(negedge clock);
    in_valid = 0;
  endtask

  task automatic send2(input logic [3:0] a, input logic [3:0] b, input bit t);
    logic [3:0] s[2];
    s[0] = a; s[1] = b;
    for (int i = 0; i < 2; i++) begin
      int w;
      @(negedge clock);
      in_valid2 = 1;
      in_data2  = s[i];
      tc2       = t;
      w = 0;
      while (!in_ready2 && w < 200) begin
        @(negedge clock);
        w++;
      end
      if (w == 200) begin
        checks++; errors++;
        $display("FAIL in_ready2 timeout actual=0 required=1 at %0t", $time);
      end
      @(posedge clock);
    end
    @(negedge clock);
    in_valid2 = 0;
  endtask

  task automatic drain;
    int w = 0;
    while ((q8.size() != 0 || q2.size() != 0) && w < 1000) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (w == 1000) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0", q8.size(), q2.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s[8];
    res_t       e;
    int         w;
    reset = 1; tc = 0; in_valid = 0; in_data = 0;
    tc2 = 0; in_valid2 = 0; in_data2 = 0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_min", out_min, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_in_ready2", in_ready2, 1);
    @(negedge clock);
    @(negedge clock);
    reset = 0;

    // Unsigned frame back-to-back, then 5 cycles of backpressure.
    force8 = 0;
    @(negedge clock);
    @(negedge clock);
    q8.push_back(mk(4'd0, 2, 4'd15, 3, 1'b0));
    s = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd7, 4'd7, 4'd1, 4'd2};
    send8(s, 0, 0, 0, 8);
    #1;
    chk("latency_valid", out_valid, 1);
    chk("latency_busy", busy, 0);
    for (int k = 0; k < 5; k++) begin
      e = q8[0];
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_min", out_min, e.mn);
      chk("hold_max", out_max, e.mx);
      chk("hold_min_idx", out_min_idx, e.mni);
      chk("hold_max_idx", out_max_idx, e.mxi);
      @(negedge clock);
      #1;
    end
    force8 = 1;
    w = 0;
    while (out_valid && w < 10) begin
      @(negedge clock);
      #1;
      w++;
    end
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_min_kept", out_min, 4'd0);

    // Signed frame with random gaps; tie on max at idx 5 must be ignored.
    q8.push_back(mk(4'b1001, 1, 4'd7, 4, 1'b1));
    send8(s, 1, 1, 50, 8);

    // tc raised after sample 2: frame stays unsigned.
    q8.push_back(mk(4'd1, 1, 4'd8, 0, 1'b0));
    s = '{4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1, 4'd8, 4'd1};
    send8(s, 0, 1, 0, 8);

    // Random frames, random gaps, random backpressure, random mid-frame tc.
    rr_rand = 1;
    for (int f = 0; f < 25; f++) begin
      bit t0, t1;
      foreach (s[j]) s[j] = 4'($urandom);
      t0 = 1'($urandom % 2);
      t1 = 1'($urandom % 2);
      q8.push_back(model8(s, t0));
      send8(s, t0, t1, 30, 8);
    end
    rr_rand = 0;
    force8  = 1;
    drain();

    // Reset after 4 accepts: everything clears asynchronously.
    s = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    send8(s, 1, 1, 0, 4);
    #1;
    chk("midframe_busy", busy, 1);
    #1;
    reset = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_min", out_min, 0);
    chk("arst_out_max", out_max, 0);
    chk("arst_out_tc", out_tc, 0);
    chk("arst_out_max_idx", out_max_idx, 0);
    @(negedge clock);
    reset = 0;
    q8.push_back(mk(4'd8, 0, 4'd8, 0, 1'b0));
    s = '{default: 4'b1000};
    send8(s, 0, 0, 0, 8);

    // Exhaustive ordering on 2-sample frames.
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          logic [3:0] pq[$];
          pq = {4'(a), 4'(b)};
          q2.push_back(model(pq, 1'(t)));
          send2(4'(a), 4'(b), 1'(t));
        end
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
